fir_sample_feeder: RTL and testbench



---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_sample_fifo.sv | 65 ++++++
 rtl/fir_sample_feeder.sv | 124 ++++++++++++
 tb/tb_fir_sample_feeder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample feeder: FSM state encoding and
// default widths used by the feeder and its sample FIFO.
package fir_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int MAX_TAPS     = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_WAIT    = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Sample FIFO for the FIR feeder: power-of-2 ring buffer with occupancy count.
// Flush and reset both empty it; flush beats any push or pop in the same cycle.
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = SAMPLE_W_DEF + 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;
    logic w_clear;

    assign w_clear   = rst || i_flush;
    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop && (r_count != '0);

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!w_clear && w_do_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds queued AXI-Stream samples one at a time into an FIR datapath:
// LOAD strobes the sample, COMPUTE kicks the datapath, WAIT awaits its reply.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int SAMPLE_W = SAMPLE_W_DEF,
    parameter  int TIMEOUT  = 64,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                flush,
    input  logic [SAMPLE_W-1:0] s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [SAMPLE_W-1:0] input_data,
    output logic                input_data_valid,
    output logic                compute,
    input  logic                output_data_valid,
    output logic [CW-1:0]       fifo_count,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout_err
);

    localparam int             TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 2);

    fsm_state_t          r_state;
    fsm_state_t          w_next;
    logic [SAMPLE_W-1:0] r_data;
    logic                r_last;
    logic [TW-1:0]       r_tcnt;
    logic                r_terr;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_reply;
    logic                w_expire;
    logic [SAMPLE_W:0]   w_head;
    logic [CW-1:0]       w_count;

    assign s_axis_tready = !w_full && !flush && !rst;
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_pop         = (r_state == ST_LOAD);

    fir_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_wdata ({s_axis_tlast, s_axis_tdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    // The timeout counter holds cycles-since-compute minus one, so expiring at
    // TMO_LAST makes timeout_err visible exactly TIMEOUT cycles after compute.
    always_comb begin
        w_next   = r_state;
        w_reply  = 1'b0;
        w_expire = 1'b0;
        case (r_state)
            ST_IDLE:    if (enable && (w_count != '0)) w_next = ST_LOAD;
            ST_LOAD:    w_next = ST_COMPUTE;
            ST_COMPUTE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (output_data_valid) begin
                    w_reply = 1'b1;
                    w_next  = ST_IDLE;
                end else if (r_tcnt == TMO_LAST) begin
                    w_expire = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
        if (flush)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_tcnt  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Latch the head as LOAD begins so input_data holds between strobes.
            if (r_state == ST_IDLE && w_next == ST_LOAD) begin
                r_data <= w_head[SAMPLE_W-1:0];
                r_last <= w_head[SAMPLE_W];
            end
            if (r_state == ST_COMPUTE)
                r_tcnt <= '0;
            else if (r_state == ST_WAIT)
                r_tcnt <= r_tcnt + 1'b1;
            if (flush)
                r_terr <= 1'b0;
            else if (w_expire)
                r_terr <= 1'b1;
        end
    end

    assign input_data       = r_data;
    assign input_data_valid = (r_state == ST_LOAD);
    assign compute          = (r_state == ST_COMPUTE);
    assign busy             = (r_state != ST_IDLE);
    assign frame_done       = w_reply && r_last && !flush && !rst;
    assign timeout_err      = r_terr;
    assign fifo_count       = w_count;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboarded bench for fir_sample_feeder: accepted samples are queued and
// popped by a monitor on each input_data_valid; a datapath model replies.
module tb_fir_sample_feeder;

    localparam int DEPTH = 16;
    localparam int SW    = 16;
    localparam int TMO   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic [SW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [SW-1:0] input_data;
    logic          input_data_valid;
    logic          compute;
    logic          output_data_valid;
    logic [4:0]    fifo_count;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_samples = 0;
    int fd_cnt = 0;
    int fd_sample = 0;
    int last_ld = -100;
    logic inflight_last = 1'b0;
    logic [SW:0] sb [$];

    bit reply_en = 1'b1;
    int reply_delay = 3;

    fir_sample_feeder #(.DEPTH(DEPTH), .SAMPLE_W(SW), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .flush             (flush),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tready     (s_axis_tready),
        .input_data        (input_data),
        .input_data_valid  (input_data_valid),
        .compute           (compute),
        .output_data_valid (output_data_valid),
        .fifo_count        (fifo_count),
        .busy              (busy),
        .frame_done        (frame_done),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Datapath model: completion pulse reply_delay cycles after compute.
    initial begin
        output_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (compute && reply_en) begin
                repeat (reply_delay) @(posedge clk);
                #1 output_data_valid = 1'b1;
                @(posedge clk);
                #1 output_data_valid = 1'b0;
            end
        end
    end

    // Monitor: order, spacing and frame_done against the scoreboard.
    initial forever begin
        logic [SW:0] exp;
        @(negedge clk);
        if (!rst) begin
            if (input_data_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample got=%h expected=none", input_data);
                end else begin
                    exp = sb.pop_front();
                    inflight_last = exp[SW];
                    if (input_data !== exp[SW-1:0]) begin
                        errors++;
                        $display("FAIL sample_order got=%h expected=%h", input_data, exp[SW-1:0]);
                    end
                end
                checks++;
                if (cyc - last_ld < 4) begin
                    errors++;
                    $display("FAIL sample_spacing got=%0d expected>=4", cyc - last_ld);
                end
                last_ld = cyc;
                n_samples++;
            end
            if (frame_done) begin
                checks++;
                if (!inflight_last) begin
                    errors++;
                    $display("FAIL frame_done_tlast got=1 expected=0");
                end
                fd_cnt++;
                fd_sample = n_samples;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [SW-1:0] d, input logic l);
        int g;
        logic acc;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        g = 0;
        do begin
            @(negedge clk);
            acc = s_axis_tready;
            tick();
            g++;
        end while (!acc && g < 300);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checks++;
        if (acc) sb.push_back({l, d});
        else begin
            errors++;
            $display("FAIL push_accept got=0 expected=1 data=%h", d);
        end
    endtask

    task automatic wait_idle(input int bound);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy || fifo_count != 0) && g < bound);
        checks++;
        if (busy || fifo_count != 0) begin
            errors++;
            $display("FAIL drain_idle got=busy%0d/cnt%0d expected=0/0", busy, fifo_count);
        end
        tick();
    endtask

    task automatic wait_compute(output int c);
        int g = 0;
        while (!compute && g < 60) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!compute) begin
            errors++;
            $display("FAIL compute_seen got=0 expected=1");
        end
        c = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h5555; s_axis_tlast = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idv", input_data_valid, 0);
        chk("rst_compute", compute, 0);
        chk("rst_data", input_data, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_terr", timeout_err, 0);
        tick();
        rst = 1'b0; s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", s_axis_tready, 1);
        chk("post_rst_count", fifo_count, 0);
        tick();
    endtask

    task automatic test_latency;
        enable = 1'b1; reply_delay = 3;
        push(16'h0A0B, 1'b0);
        @(negedge clk);
        chk("lat_c1_idv", input_data_valid, 0);
        chk("lat_c1_count", fifo_count, 1);
        tick();
        @(negedge clk);
        chk("lat_c2_idv", input_data_valid, 1);
        chk("lat_c2_data", input_data, 16'h0A0B);
        tick();
        @(negedge clk);
        chk("lat_c3_compute", compute, 1);
        chk("lat_c3_idv", input_data_valid, 0);
        chk("lat_hold_data", input_data, 16'h0A0B);
        wait_idle(50);
    endtask

    task automatic test_three_frame;
        int n0 = n_samples;
        int f0 = fd_cnt;
        push(16'h0010, 1'b0);
        push(16'h0020, 1'b0);
        push(16'h0030, 1'b1);
        wait_idle(200);
        tick();
        chk("three_samples", n_samples - n0, 3);
        chk("three_fd", fd_cnt - f0, 1);
        chk("three_fd_after", fd_sample, n0 + 3);
    endtask

    task automatic test_enable_drop;
        int g = 0;
        int f0 = fd_cnt;
        enable = 1'b0;
        push(16'h0101, 1'b0);
        push(16'h0202, 1'b1);
        enable = 1'b1;
        do begin @(negedge clk); g++; end while (!input_data_valid && g < 20);
        enable = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (busy && g < 50);
        chk("endrop_idle", busy, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("endrop_parked", busy, 0);
        chk("endrop_count", fifo_count, 1);
        tick();
        enable = 1'b1;
        wait_idle(50);
        tick();
        chk("endrop_fd", fd_cnt - f0, 1);
    endtask

    task automatic test_full;
        int n0;
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(16'h1000 + 16'(i), i == DEPTH - 1);
        @(negedge clk);
        chk("full_count", fifo_count, 16);
        chk("full_tready", s_axis_tready, 0);
        tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'hDEAD;
        repeat (3) tick();
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("full_17th_dropped", fifo_count, 16);
        tick();
        n0 = n_samples;
        enable = 1'b1;
        wait_idle(400);
        chk("full_drained", n_samples - n0, 16);
    endtask

    task automatic test_timeout;
        int c;
        int t;
        int g = 0;
        reply_en = 1'b0; enable = 1'b1;
        push(16'h0C0C, 1'b0);
        wait_compute(c);
        do begin @(negedge clk); g++; end while (!timeout_err && g < 2 * TMO);
        t = cyc;
        chk("tmo_latency", t - c, TMO);
        chk("tmo_idle", busy, 0);
        tick();
        reply_en = 1'b1; reply_delay = 2;
        push(16'h0D0D, 1'b1);
        wait_idle(50);
        chk("tmo_sticky", timeout_err, 1);
    endtask

    task automatic test_flush;
        int c;
        int f0 = fd_cnt;
        enable = 1'b0; reply_delay = 10;
        for (int i = 0; i < 6; i++) push(16'h2000 + 16'(i), 1'b1);
        enable = 1'b1;
        wait_compute(c);
        tick();
        @(negedge clk);
        chk("flush_pre_count", fifo_count, 5);
        chk("flush_pre_terr", timeout_err, 1);
        tick();
        flush = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h7777; s_axis_tlast = 1'b1;
        @(negedge clk);
        chk("flush_tready", s_axis_tready, 0);
        tick();
        flush = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_count", fifo_count, 0);
        chk("flush_busy", busy, 0);
        chk("flush_terr", timeout_err, 0);
        repeat (15) tick();
        @(negedge clk);
        chk("flush_no_fd", fd_cnt - f0, 0);
        chk("flush_stay_idle", busy, 0);
        chk("flush_push_absent", fifo_count, 0);
        tick();
    endtask

    task automatic test_same_cycle;
        enable = 1'b0; reply_delay = 1;
        for (int i = 0; i < 4; i++) push(16'h3000 + 16'(i), 1'b0);
        enable = 1'b1;
        tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h3004; s_axis_tlast = 1'b1;
        @(negedge clk);
        chk("pp_load", input_data_valid, 1);
        chk("pp_tready", s_axis_tready, 1);
        chk("pp_count_before", fifo_count, 4);
        sb.push_back({1'b1, 16'h3004});
        tick();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        @(negedge clk);
        chk("pp_count_after", fifo_count, 4);
        wait_idle(100);
    endtask

    task automatic test_wrap;
        int n0 = n_samples;
        int f0 = fd_cnt;
        enable = 1'b1; reply_delay = 1;
        for (int i = 0; i < 40; i++) push(16'h4000 + 16'(i * 7), i == 39);
        wait_idle(600);
        tick();
        chk("wrap_samples", n_samples - n0, 40);
        chk("wrap_fd", fd_cnt - f0, 1);
    endtask

    task automatic test_reset_mid;
        int c;
        int f0 = fd_cnt;
        enable = 1'b1; reply_delay = 3;
        push(16'h5555, 1'b1);
        wait_compute(c);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_busy", busy, 0);
        repeat (6) tick();
        @(negedge clk);
        chk("rmid_no_fd", fd_cnt - f0, 0);
        chk("rmid_idle", busy, 0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_three_frame();
        test_enable_drop();
        test_full();
        test_timeout();
        test_flush();
        test_same_cycle();
        test_wrap();
        test_reset_mid();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
